// File: rtl/shift_normalizer_pkg.sv
// Shared types and constants for the shift_normalizer block.
package shift_normalizer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 32;
  localparam int CW_DEF    = 6;
  localparam int STEPS     = 5;

endpackage

// File: rtl/shift_normalizer_step.sv
// One binary-search step of the normalizer.
// CLZ (mode=0): take when the top k bits are all zero.
// CLS (mode=1): take when the top k+1 bits are all equal.
// When take is set, the caller uses shifted = work << k (zero fill).
module shift_normalizer_step #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] work,
  input  logic [CW-1:0]    k,
  input  logic             mode,
  output logic             take,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] mask_k, mask_k1, top_k, top_k1;

  // Build masks for the top k / k+1 bits and test them.
  always_comb begin
    mask_k  = ~({WIDTH{1'b1}} >> k);
    mask_k1 = ~({WIDTH{1'b1}} >> (k + CW'(1)));
    top_k   = work & mask_k;
    top_k1  = work & mask_k1;
    if (mode) take = (top_k1 == '0) || (top_k1 == mask_k1);
    else      take = (top_k == '0);
    shifted = work << k;
  end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: CLZ / CLS shift count plus normalized operand,
// using a fixed-latency binary search (one step per cycle).
// Optional macro SHIFT_NORMALIZER_BACK2BACK_EN lets a new operand be
// accepted on the same edge the result is consumed.
module shift_normalizer
  import shift_normalizer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic [WIDTH-1:0] out_norm,
  output logic             out_zero
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int SW    = $clog2(LOG2W);
  localparam logic [SW-1:0] STEP_INIT = SW'(LOG2W - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q;
  logic [CW-1:0]    cnt_q;
  logic             mode_q;
  logic             zero_q;
  logic [SW-1:0]    step_q;

  logic [CW-1:0]    k;
  logic             take;
  logic [WIDTH-1:0] work_sh;
  logic             accept;
  logic             zero_det;
  logic             last_step;
  logic [CW-1:0]    res_cnt;
  logic [WIDTH-1:0] res_norm;

  assign k         = CW'(1) << step_q;
  assign accept    = in_valid && in_ready;
  assign last_step = (state_q == SHIFT) && (step_q == '0);
  assign out_valid = (state_q == DONE);
  assign zero_det  = in_signed ? ((in_data == '0) || (&in_data)) : (in_data == '0);
  assign res_cnt   = take ? (cnt_q + k) : cnt_q;
  assign res_norm  = take ? work_sh : work_q;

  shift_normalizer_step #(.WIDTH(WIDTH), .CW(CW)) u_step (
    .work    (work_q),
    .k       (k),
    .mode    (mode_q),
    .take    (take),
    .shifted (work_sh)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and input-side ready.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = rst_n;
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (step_q == '0) state_d = DONE;
      end
      DONE: begin
`ifdef SHIFT_NORMALIZER_BACK2BACK_EN
        in_ready = rst_n && out_ready;
`endif
        if (out_ready) state_d = accept ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Search datapath: load on accept, one conditional shift per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      zero_q <= 1'b0;
      step_q <= STEP_INIT;
    end else if (accept) begin
      work_q <= in_data;
      cnt_q  <= '0;
      mode_q <= in_signed;
      zero_q <= zero_det;
      step_q <= STEP_INIT;
    end else if (state_q == SHIFT) begin
      work_q <= res_norm;
      cnt_q  <= res_cnt;
      // Park the index at its start value once the search finishes.
      step_q <= (step_q == '0) ? STEP_INIT : step_q - SW'(1);
    end
  end

  // Result registers: captured on entry to DONE, held until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
      out_norm  <= '0;
      out_zero  <= 1'b0;
    end else if (last_step) begin
      out_zero <= zero_q;
      // All-zero CLZ operand reports the full width; search alone tops out at WIDTH-1.
      if (zero_q && !mode_q) begin
        out_count <= CW'(WIDTH);
        out_norm  <= '0;
      end else begin
        out_count <= res_cnt;
        out_norm  <= res_norm;
      end
    end
  end

endmodule

// File: tb/tb_shift_normalizer.sv
// Scoreboard bench for shift_normalizer: expected results are queued at
// accept and compared when the result handshake happens.
module tb_shift_normalizer;

  typedef struct packed {
    logic [5:0]  count;
    logic [31:0] norm;
    logic        zero;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_count;
  logic [31:0] out_norm;
  logic        out_zero;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  res_t sb_q[$];
  int   acc_q[$];
  logic prev_valid = 1'b0;
  logic tp_mode = 1'b0;
  int   tp_last = -1;

`ifdef SHIFT_NORMALIZER_BACK2BACK_EN
  localparam int GAP = 6;
`else
  localparam int GAP = 7;
`endif

  shift_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_norm  (out_norm),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] d, input logic s);
    res_t r;
    int n = 0;
    if (!s) begin
      while (n < 32 && d[31-n] == 1'b0) n++;
      r.zero = (d == 32'h0);
    end else begin
      while (n < 31 && d[30-n] == d[31]) n++;
      r.zero = (d == 32'h0) || (d == 32'hFFFF_FFFF);
    end
    r.count = 6'(n);
    r.norm  = (n >= 32) ? 32'h0 : d << n;
    return r;
  endfunction

  // Monitor: queue expectations at accept, check latency and results at output.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        sb_q.push_back(model(in_data, in_signed));
        acc_q.push_back(cyc + 1);
        if (tp_mode && tp_last >= 0) chk("gap", 64'(cyc + 1 - tp_last), 64'(GAP));
        if (tp_mode) tp_last = cyc + 1;
      end
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) chk("lat_noacc", 1, 0);
        else chk("latency", 64'(cyc - acc_q.pop_front()), 64'd5);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk("sb_empty", 1, 0);
        else begin
          res_t e;
          e = sb_q.pop_front();
          chk("count", 64'(out_count), 64'(e.count));
          chk("norm",  64'(out_norm),  64'(e.norm));
          chk("zero",  64'(out_zero),  64'(e.zero));
        end
      end
      prev_valid <= out_valid;
    end
  end

  task automatic send(input logic [31:0] d, input logic s);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_signed = s;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 50) begin @(posedge clk); #2; t++; end
    if (t >= 50) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d_vec[9] = '{32'h0001_0000, 32'h0000_0000, 32'h8000_0000,
                              32'hFFFF_8000, 32'h0000_0001, 32'hFFFF_FFFF,
                              32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0001};
    logic       s_vec[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0]  c0;
    logic [31:0] n0;
    logic        z0;
    int t;

    // Reset state.
    #3;
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_count", 64'(out_count), 0);
    chk("rst_norm", 64'(out_norm), 0);
    chk("rst_zero", 64'(out_zero), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("idle_in_ready", 64'(in_ready), 1);

    // Directed vectors, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(d_vec[i], s_vec[i]);
      drain();
    end

    // Backpressure: result held, no second accept.
    out_ready = 1'b0;
    send(32'h0000_F000, 1'b0);
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    chk("bp_valid", 64'(out_valid), 1);
    c0 = out_count; n0 = out_norm; z0 = out_zero;
    chk("bp_count", 64'(c0), 64'd16);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid; in_data = $urandom; in_signed = $urandom_range(0, 1);
      @(negedge clk);
      chk("bp_hold_count", 64'(out_count), 64'(c0));
      chk("bp_hold_norm", 64'(out_norm), 64'(n0));
      chk("bp_hold_zero", 64'(out_zero), 64'(z0));
      chk("bp_in_ready", 64'(in_ready), 0);
      chk("bp_hold_valid", 64'(out_valid), 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 64'(out_valid), 0);
    chk("bp_sb_empty", 64'(sb_q.size()), 0);

    // Reset in the third SHIFT cycle drops the operation.
    send(32'h1234_5678, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(out_valid), 0);
    chk("abort_count", 64'(out_count), 0);
    chk("abort_norm", 64'(out_norm), 0);
    chk("abort_in_ready", 64'(in_ready), 0);
    sb_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    send(32'h0000_0100, 1'b0);
    drain();
    chk("post_abort_count", 64'(out_count), 64'd23);

    // Throughput with continuous valid and ready.
    @(posedge clk); #1;
    tp_mode = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      in_data = $urandom;
      in_signed = $urandom_range(0, 1);
      if (i % 5 == 0) in_data = in_data >> $urandom_range(0, 31);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tp_mode = 1'b0;
    drain();
    chk("final_sb_empty", 64'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_normalizer.md
Name: shift_normalizer

Overview:
- Multi-cycle normalizer: the inverse of the datapath barrel shifter. It takes a 32-bit operand and produces the left-shift amount that normalizes it, plus the normalized value.
- Unsigned mode gives the leading-zero count (CLZ). Signed mode gives the redundant-sign-bit count (CLS).
- Sits beside the ALU as a stallable functional unit, with a valid/ready handshake on both sides.
- Uses a 5-step binary search, one step per cycle, with fixed latency.

Parameters:
- WIDTH, 32, operand width; must be a power of 2 and at least 8.
- CW, $clog2(WIDTH)+1, count width (6 at the default WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand offered.
- in_ready  output  1  unit can accept an operand.
- in_data  input  WIDTH  operand; sampled only on the accept edge.
- in_signed  input  1  0 = CLZ mode, 1 = CLS mode; sampled with in_data.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_count  output  CW  shift amount.
- out_norm  output  WIDTH  in_data << out_count, zero-filled.
- out_zero  output  1  operand was all-zero (CLZ) or all-zero/all-ones (CLS).

Behaviour:
- States: IDLE, SHIFT, DONE.
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - out_valid = 0, out_count = 0, out_norm = 0, out_zero = 0.
  - Internal step index = log2(WIDTH)-1.
  - in_ready forced to 0 while rst_n is low.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: load work register = in_data, count = 0, mode = in_signed, step = 4.
  - Zero flag is set on accept: CLZ if in_data == 0; CLS if in_data is all 0s or all 1s.
  - Go to SHIFT.
- SHIFT:
  - in_ready = 0. One step per cycle, with k = 2^step.
  - CLZ step: if the top k bits of the work register are all 0, shift the register left by k and add k to count.
  - CLS step: if the top k+1 bits are all equal, shift left by k (zero fill) and add k to count.
  - Decrement step. After the k = 1 step, go to DONE.
- Latency is fixed regardless of operand: out_valid rises 5 edges after the accept edge.
- Entering DONE:
  - If the zero flag is set and mode is CLZ, out_count = 32 and out_norm = 0.
  - Otherwise out_count and out_norm take the search result. CLS range is 0..31, and all-0s or all-1s gives 31.
- DONE:
  - out_valid = 1.
  - out_count, out_norm and out_zero are held stable while out_ready = 0.
  - On out_ready, go to IDLE and drop out_valid on that edge.
- in_valid while the unit is busy is ignored. No queueing; in_data changes while busy have no effect.
- Reset asserted mid-SHIFT or in DONE: the result is lost and the unit is immediately in IDLE with outputs cleared.
- Arithmetic: count uses CW-bit unsigned accumulation. It cannot overflow, since the search maximum is 31 and 32 comes only from the zero override.

Optional Feature:
- Macro: SHIFT_NORMALIZER_BACK2BACK_EN
- Defined:
  - In DONE, in_ready = out_ready.
  - An output handshake and a new input accept may occur on the same edge; the unit goes DONE→SHIFT directly.
  - Sustained throughput is one result per 6 cycles.
- Undefined:
  - in_ready = 1 only in IDLE, so at least one IDLE cycle separates results.
  - Sustained throughput is one result per 7 cycles.

Decomposition:
- Package shift_normalizer_pkg holds:
  - the state encoding (IDLE = 0, SHIFT = 1, DONE = 2, 2 bits);
  - WIDTH_DEF = 32;
  - CW_DEF = 6;
  - STEPS = 5.
- One natural sub-module, shift_normalizer_step: a combinational single search step. Inputs are the work register, k and mode. Outputs are the take flag and the shifted value.

Test Plan:
- CLZ in_data = 0x00010000 → out_valid 5 edges after accept; out_count = 15, out_norm = 0x80000000, out_zero = 0.
- CLZ in_data = 0x00000000 → out_count = 32, out_norm = 0, out_zero = 1. CLZ in_data = 0x80000000 → out_count = 0, norm unchanged.
- CLS in_data = 0xFFFF8000 → out_count = 16, out_norm = 0x80000000. CLS 0x00000001 → 30, norm 0x40000000. CLS 0xFFFFFFFF → 31, out_zero = 1.
- Backpressure: hold out_ready = 0 for 4 cycles in DONE while toggling in_valid and in_data → outputs stable, in_ready = 0, no second accept; out_ready = 1 → IDLE next edge.
- Reset pulse during the 3rd SHIFT cycle → outputs 0 immediately; after release a fresh CLZ 0x00000100 yields 23, unaffected by the aborted operand.
- Continuous in_valid and out_ready = 1 → accepts every 7 cycles (macro off) or every 6 cycles (SHIFT_NORMALIZER_BACK2BACK_EN on); results in order.
